// File: rtl/alu_cmd_issuer.sv
// Command issuer for an external combinational ALU: launches one operation, waits SETTLE cycles,
// captures and carry-checks the result, then holds it until the consumer takes it.
module alu_cmd_issuer #(
    parameter int unsigned NBITS  = 15,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [NBITS:0]   cmd_a_i,
    input  logic [NBITS:0]   cmd_b_i,
    input  logic [2:0]       cmd_op_i,
    output logic [NBITS:0]   alu_a_o,
    output logic [NBITS:0]   alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [NBITS+1:0] alu_y_i,
    input  logic             alu_co_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [NBITS+1:0] rsp_y_o,
    output logic             rsp_co_o,
    output logic [2:0]       rsp_op_o,
    output logic             rsp_err_o,
    output logic [7:0]       cmd_count_o,
    output logic [7:0]       err_count_o
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [2:0]       settle_q, settle_d;
    logic [NBITS:0]   alu_a_q, alu_a_d;
    logic [NBITS:0]   alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [NBITS+1:0] rsp_y_q, rsp_y_d;
    logic             rsp_co_q, rsp_co_d;
    logic [2:0]       rsp_op_q, rsp_op_d;
    logic             rsp_err_q, rsp_err_d;
    logic [7:0]       cmd_count_q, cmd_count_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             carry_err;

    // Ops 4 and 7 never produce a carry; every other op must report carry equal to the result MSB.
    always_comb begin
        carry_err = 1'b0;
        if (alu_op_q == 3'd4 || alu_op_q == 3'd7) begin
            carry_err = alu_co_i;
        end else begin
            carry_err = alu_co_i ^ alu_y_i[NBITS+1];
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_co_d    = rsp_co_q;
        rsp_op_d    = rsp_op_q;
        rsp_err_d   = rsp_err_q;
        cmd_count_d = cmd_count_q;
        err_count_d = err_count_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    alu_a_d  = cmd_a_i;
                    alu_b_d  = cmd_b_i;
                    alu_op_d = cmd_op_i;
                    settle_d = 3'(SETTLE);
                    state_d  = StWait;
                end
            end
            StWait: begin
                settle_d = settle_q - 3'd1;
                if (settle_q == 3'd1) begin
                    rsp_y_d     = alu_y_i;
                    rsp_co_d    = alu_co_i;
                    rsp_op_d    = alu_op_q;
                    rsp_err_d   = carry_err;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_count_d = cmd_count_q + 8'd1;
                    if (rsp_err_q && err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            settle_q    <= 3'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_co_q    <= 1'b0;
            rsp_op_q    <= 3'd0;
            rsp_err_q   <= 1'b0;
            cmd_count_q <= 8'd0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_co_q    <= rsp_co_d;
            rsp_op_q    <= rsp_op_d;
            rsp_err_q   <= rsp_err_d;
            cmd_count_q <= cmd_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_op_o    = alu_op_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_y_o     = rsp_y_q;
    assign rsp_co_o    = rsp_co_q;
    assign rsp_op_o    = rsp_op_q;
    assign rsp_err_o   = rsp_err_q;
    assign cmd_count_o = cmd_count_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: a stub ALU with optional carry corruption, a driver that
// pushes expected responses, and a monitor that pops and compares on each response handshake.
module tb_alu_cmd_issuer;

    localparam int unsigned NBITS   = 15;
    localparam int unsigned SETTLE  = 3;
    localparam int          MAXWAIT = 200;

    typedef struct {
        logic [NBITS+1:0] y;
        logic             co;
        logic [2:0]       op;
        logic             err;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [NBITS:0]   cmd_a = '0;
    logic [NBITS:0]   cmd_b = '0;
    logic [2:0]       cmd_op = '0;
    logic [NBITS:0]   alu_a, alu_b;
    logic [2:0]       alu_op;
    logic [NBITS+1:0] alu_y;
    logic             alu_co;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [NBITS+1:0] rsp_y;
    logic             rsp_co;
    logic [2:0]       rsp_op;
    logic             rsp_err;
    logic [7:0]       cmd_count, err_count;

    logic fault_cur = 1'b0;
    int   ready_mode = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_acc = 0;
    exp_t sb[$];

    alu_cmd_issuer #(.NBITS(NBITS), .SETTLE(SETTLE)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_op_i(cmd_op),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_y_i(alu_y), .alu_co_i(alu_co),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_y_o(rsp_y), .rsp_co_o(rsp_co), .rsp_op_o(rsp_op), .rsp_err_o(rsp_err),
        .cmd_count_o(cmd_count), .err_count_o(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal ALU behaviour in plain signed integer arithmetic.
    function automatic logic [NBITS+1:0] ref_y(input logic [NBITS:0] a, input logic [NBITS:0] b,
                                               input logic [2:0] op);
        int sa, sbv, r;
        sa  = $signed(a);
        sbv = $signed(b);
        case (op)
            3'd0:    r = sa + sbv;
            3'd1:    r = sbv - sa;
            3'd2:    r = 2 * sa;
            3'd3:    r = sa - sbv;
            3'd4:    r = sa;
            3'd5:    r = -sa;
            3'd6:    r = sbv;
            default: r = sa ^ sbv;
        endcase
        return r[NBITS+1:0];
    endfunction

    function automatic logic ref_co(input logic [NBITS+1:0] y, input logic [2:0] op);
        return (op == 3'd4 || op == 3'd7) ? 1'b0 : y[NBITS+1];
    endfunction

    always_comb begin
        alu_y  = ref_y(alu_a, alu_b, alu_op);
        alu_co = ref_co(alu_y, alu_op) ^ fault_cur;
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [NBITS:0] rand_opnd();
        case ($urandom_range(0, 4))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return NBITS'($urandom) | {($urandom_range(0, 1) == 1), {NBITS{1'b0}}};
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ($urandom_range(0, 1) == 1);
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [NBITS:0] a, input logic [NBITS:0] b, input logic [2:0] op,
                         input logic flt);
        int   guard;
        exp_t e;
        guard     = 0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_valid = 1'b1;
        while (!cmd_ready && guard < MAXWAIT) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check("issue_timeout", {31'd0, cmd_ready}, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        e.y   = ref_y(a, b, op);
        e.co  = ref_co(e.y, op) ^ flt;
        e.op  = op;
        e.err = flt;
        e.acc = cyc + 1;
        last_acc = e.acc;
        sb.push_back(e);
        @(negedge clk);
        fault_cur = flt;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || rsp_valid) && guard < MAXWAIT) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: latency, stability under backpressure, response contents and counters.
    initial begin
        exp_t             e;
        logic             prev_hold;
        logic             cnt_chk;
        int               exp_cmd, exp_err;
        logic [NBITS+1:0] h_y;
        logic             h_co, h_err;
        logic [2:0]       h_op;
        prev_hold = 1'b0;
        cnt_chk   = 1'b0;
        exp_cmd   = 0;
        exp_err   = 0;
        h_y = '0; h_co = 1'b0; h_err = 1'b0; h_op = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                exp_cmd   = 0;
                exp_err   = 0;
                prev_hold = 1'b0;
                cnt_chk   = 1'b0;
                continue;
            end
            if (cnt_chk) begin
                check("cmd_count", {24'd0, cmd_count}, exp_cmd);
                check("err_count", {24'd0, err_count}, exp_err);
                cnt_chk = 1'b0;
            end
            if (rsp_valid) check("cmd_ready_in_resp", {31'd0, cmd_ready}, 32'd0);
            if (rsp_valid && !prev_hold) begin
                if (sb.size() == 0) check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                else check("latency", cyc - sb[0].acc, SETTLE);
                h_y = rsp_y; h_co = rsp_co; h_op = rsp_op; h_err = rsp_err;
            end else if (rsp_valid) begin
                check("hold_y", rsp_y, h_y);
                check("hold_co", {31'd0, rsp_co}, {31'd0, h_co});
                check("hold_op", {29'd0, rsp_op}, {29'd0, h_op});
                check("hold_err", {31'd0, rsp_err}, {31'd0, h_err});
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("rsp_y", rsp_y, e.y);
                check("rsp_co", {31'd0, rsp_co}, {31'd0, e.co});
                check("rsp_op", {29'd0, rsp_op}, {29'd0, e.op});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                exp_cmd = (exp_cmd + 1) % 256;
                if (e.err && exp_err < 255) exp_err++;
                cnt_chk = 1'b1;
            end
            prev_hold = rsp_valid && !rsp_ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_acc;
        logic [NBITS:0] bp_a;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("rst_alu_b", {16'd0, alu_b}, 32'd0);
        check("rst_alu_op", {29'd0, alu_op}, 32'd0);
        check("rst_rsp_y", {15'd0, rsp_y}, 32'd0);
        check("rst_rsp_co_err", {30'd0, rsp_co, rsp_err}, 32'd0);
        check("rst_rsp_op", {29'd0, rsp_op}, 32'd0);
        check("rst_counts", {16'd0, cmd_count, err_count}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Directed results.
        issue(16'd5, 16'd3, 3'd0, 1'b0);
        issue(16'd2, 16'd7, 3'd3, 1'b0);
        issue(16'h1234, 16'd0, 3'd4, 1'b1);
        drain();
        check("dir_cmd_count", {24'd0, cmd_count}, 32'd3);
        check("dir_err_count", {24'd0, err_count}, 32'd1);

        // Backpressure: response held five cycles with commands offered meanwhile.
        ready_mode = 2;
        @(negedge clk);
        @(negedge clk);
        bp_a = 16'h0ABC;
        issue(bp_a, 16'h0101, 3'd1, 1'b0);
        for (int i = 0; i < MAXWAIT && !rsp_valid; i++) @(negedge clk);
        check("bp_valid_seen", {31'd0, rsp_valid}, 32'd1);
        cmd_a     = 16'h5555;
        cmd_op    = 3'd2;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        ready_mode = 0;
        @(negedge clk);
        check("bp_cmd_ready6", {31'd0, cmd_ready}, 32'd0);
        check("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("bp_alu_a_held", {16'd0, alu_a}, {16'd0, bp_a});
        drain();

        // Reset while the settle counter is at 2.
        cmd_a     = 16'h0F0F;
        cmd_b     = 16'h0001;
        cmd_op    = 3'd0;
        cmd_valid = 1'b1;
        check("rw_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rw_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rw_alu", {13'd0, alu_op, alu_a}, 32'd0);
        check("rw_alu_b", {16'd0, alu_b}, 32'd0);
        check("rw_counts", {16'd0, cmd_count, err_count}, 32'd0);
        for (int i = 0; i < SETTLE + 3; i++) begin
            check("rw_no_valid", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end

        // 257 back-to-back commands: count wraps, re-accept gap is minimal.
        prev_acc = 0;
        for (int i = 0; i < 257; i++) begin
            issue(rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)), 1'b0);
            if (i > 0) check("reaccept_gap", last_acc - prev_acc, SETTLE + 2);
            prev_acc = last_acc;
        end
        drain();
        check("wrap_cmd_count", {24'd0, cmd_count}, 32'd1);

        // 300 corrupted-carry responses saturate the error counter.
        for (int i = 0; i < 300; i++) begin
            issue(rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)), 1'b1);
        end
        drain();
        check("sat_err_count", {24'd0, err_count}, 32'd255);
        check("sat_cmd_count", {24'd0, cmd_count}, 32'd45);

        // Random traffic with random backpressure and occasional faults.
        ready_mode = 1;
        for (int i = 0; i < 100; i++) begin
            issue(rand_opnd(), rand_opnd(), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0));
        end
        drain();
        ready_mode = 0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
